// File: rtl/rv_pkg.sv
// Shared definitions for the core control path: opcode encodings and the
// hazard controller state type.
package rv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_op_class.sv
// Opcode classifier: which register fields an instruction reads and writes,
// and whether it is a load. Pure decode, no validity or rd==x0 qualification.
module op_class
   import rv_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic       uses_rs1_o,
   output logic       uses_rs2_o,
   output logic       writes_rd_o,
   output logic       is_load_o
);

   // Decode opcode into operand usage classes
   always_comb begin
      uses_rs1_o  = 1'b1;
      uses_rs2_o  = 1'b0;
      writes_rd_o = 1'b0;
      is_load_o   = 1'b0;
      case (opcode_i)
         OP_R: begin
            uses_rs2_o  = 1'b1;
            writes_rd_o = 1'b1;
         end
         OP_I:     writes_rd_o = 1'b1;
         OP_LOAD: begin
            writes_rd_o = 1'b1;
            is_load_o   = 1'b1;
         end
         OP_S:     uses_rs2_o  = 1'b1;
         OP_B:     uses_rs2_o  = 1'b1;
         OP_JAL: begin
            uses_rs1_o  = 1'b0;
            writes_rd_o = 1'b1;
         end
         OP_JALR:  writes_rd_o = 1'b1;
         OP_LUI: begin
            uses_rs1_o  = 1'b0;
            writes_rd_o = 1'b1;
         end
         OP_AUIPC: begin
            uses_rs1_o  = 1'b0;
            writes_rd_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the three-stage core. Tracks the instruction in
// MEM/WB, forwards its result to DE operands, stalls on outstanding loads,
// steers the PC on taken branches and halts when a load never returns.
module hazard_ctrl
   import rv_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             de_valid,
   input  logic [6:0]       de_opcode,
   input  logic [4:0]       de_rd,
   input  logic [4:0]       de_rs1,
   input  logic [4:0]       de_rs2,
   input  logic             br_taken,
   input  logic             dmem_valid,
   output logic             stall_if,
   output logic             stall_de,
   output logic             flush_if,
   output logic             pc_sel,
   output logic             fwd_a,
   output logic             fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic            cls_rs1, cls_rs2, cls_wr, cls_load;
   logic            uses_rs1, uses_rs2, writes_rd;
   logic            m_valid_q, m_valid_d;
   logic            m_wr_q, m_wr_d;
   logic            m_load_q, m_load_d;
   logic [4:0]      m_rd_q, m_rd_d;
   hz_state_e       state_q, state_d;
   logic [7:0]      wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic            in_halt, load_wait, stall, hit_a, hit_b;

   op_class u_op_class (
      .opcode_i    (de_opcode),
      .uses_rs1_o  (cls_rs1),
      .uses_rs2_o  (cls_rs2),
      .writes_rd_o (cls_wr),
      .is_load_o   (cls_load)
   );

   // DE-side usage; an rd of x0 never counts as a write, so x0 can't forward
   assign uses_rs1  = de_valid & cls_rs1;
   assign uses_rs2  = de_valid & cls_rs2;
   assign writes_rd = cls_wr & (de_rd != 5'd0);

   // A load completing this very cycle releases the pipeline immediately
   assign in_halt   = (state_q == HALT);
   assign load_wait = m_valid_q & m_load_q & ~dmem_valid;
   assign stall     = load_wait | in_halt;

   assign hit_a = uses_rs1 & m_valid_q & m_wr_q & (m_rd_q == de_rs1);
   assign hit_b = uses_rs2 & m_valid_q & m_wr_q & (m_rd_q == de_rs2);

   assign stall_if  = stall;
   assign stall_de  = stall;
   assign fwd_a     = hit_a & ~in_halt;
   assign fwd_b     = hit_b & ~in_halt;
   // Branches seen while stalled stay in DE and resolve once released
   assign pc_sel    = br_taken & de_valid & ~stall;
   assign flush_if  = pc_sel;
   assign halted    = in_halt;
   assign stall_cnt = stall_cnt_q;

   // MEM/WB tracking: advance, hold for our own load, or take a bubble
   always_comb begin
      m_valid_d = m_valid_q;
      m_wr_d    = m_wr_q;
      m_load_d  = m_load_q;
      m_rd_d    = m_rd_q;
      if (!stall) begin
         m_valid_d = de_valid;
         m_wr_d    = writes_rd;
         m_load_d  = (de_opcode == OP_LOAD);
         m_rd_d    = de_rd;
      end else if (!load_wait) begin
         m_valid_d = 1'b0;
      end
   end

   // Load-wait FSM with timeout into a terminal halt
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = 8'd0;
            if (load_wait) state_d = WAIT;
         end
         WAIT: begin
            if (dmem_valid) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = HALT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   // Stall performance counter, saturating
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   // Control state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         m_valid_q   <= 1'b0;
         m_wr_q      <= 1'b0;
         m_load_q    <= 1'b0;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         m_valid_q   <= m_valid_d;
         m_wr_q      <= m_wr_d;
         m_load_q    <= m_load_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // MEM/WB destination register number; only meaningful with m_valid_q
   always_ff @(posedge clk) begin
      m_rd_q <= m_rd_d;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: forwarding, rs2 gating, load stalls,
// branch steering, timeout halt, async reset and counter saturation.
module tb_hazard_ctrl;
   import rv_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       de_valid, br_taken, dmem_valid;
   logic [6:0] de_opcode;
   logic [4:0] de_rd, de_rs1, de_rs2;
   logic       stall_if, stall_de, flush_if, pc_sel, fwd_a, fwd_b, halted;
   logic [3:0] stall_cnt;

   typedef struct packed {
      logic       stall;
      logic       br;
      logic       fa;
      logic       fb;
      logic       halt;
      logic [3:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   hazard_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .de_valid   (de_valid),
      .de_opcode  (de_opcode),
      .de_rd      (de_rd),
      .de_rs1     (de_rs1),
      .de_rs2     (de_rs2),
      .br_taken   (br_taken),
      .dmem_valid (dmem_valid),
      .stall_if   (stall_if),
      .stall_de   (stall_de),
      .flush_if   (flush_if),
      .pc_sel     (pc_sel),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .halted     (halted),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic s, input logic b, input logic fa,
                               input logic fb, input logic h, input logic [3:0] c);
      exp_t e;
      e.stall = s; e.br = b; e.fa = fa; e.fb = fb; e.halt = h; e.cnt = c;
      return e;
   endfunction

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic dv);
      de_valid = v; de_opcode = op; de_rd = rd; de_rs1 = rs1; de_rs2 = rs2;
      br_taken = br; dmem_valid = dv;
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      chk({tag, ".sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, ".stall_if"},  stall_if,  e.stall);
         chk({tag, ".stall_de"},  stall_de,  e.stall);
         chk({tag, ".pc_sel"},    pc_sel,    e.br);
         chk({tag, ".flush_if"},  flush_if,  e.br);
         chk({tag, ".fwd_a"},     fwd_a,     e.fa);
         chk({tag, ".fwd_b"},     fwd_b,     e.fb);
         chk({tag, ".halted"},    halted,    e.halt);
         chk({tag, ".stall_cnt"}, stall_cnt, e.cnt);
      end
   endtask

   // Drive one cycle of DE inputs, record what must come out, check at negedge
   task automatic cyc(input string tag, input logic v, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic br, input logic dv, input exp_t e);
      drive(v, op, rd, rs1, rs2, br, dv);
      sb_q.push_back(e);
      @(negedge clk);
      compare_out(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      sb_q.push_back(mk(0, 0, 0, 0, 0, 4'd0));
      @(negedge clk);
      compare_out("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Forwarding and x0 handling
      cyc("fw_add",    1, OP_R, 5'd5, 5'd1, 5'd2, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));
      cyc("fw_sub",    1, OP_R, 5'd6, 5'd5, 5'd5, 0, 0, mk(0, 0, 1, 1, 0, 4'd0));
      cyc("x0_wr",     1, OP_R, 5'd0, 5'd1, 5'd2, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));
      cyc("x0_rd",     1, OP_R, 5'd9, 5'd0, 5'd0, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));
      // rs2 field of an I-type must not forward
      cyc("addi_x7",   1, OP_I, 5'd7, 5'd1, 5'd9, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));
      cyc("rs2_gate",  1, OP_I, 5'd8, 5'd1, 5'd7, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));

      // Load wait: three stall cycles then release with forwarding
      cyc("lw_x3",     1, OP_LOAD, 5'd3, 5'd2, 5'd0, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));
      cyc("lw_st1",    1, OP_R, 5'd4, 5'd3, 5'd1, 0, 0, mk(1, 0, 1, 0, 0, 4'd0));
      cyc("lw_st2",    1, OP_R, 5'd4, 5'd3, 5'd1, 0, 0, mk(1, 0, 1, 0, 0, 4'd1));
      cyc("lw_st3",    1, OP_R, 5'd4, 5'd3, 5'd1, 0, 0, mk(1, 0, 1, 0, 0, 4'd2));
      cyc("lw_rel",    1, OP_R, 5'd4, 5'd3, 5'd1, 0, 1, mk(0, 0, 1, 0, 0, 4'd3));

      // Taken branch without stall
      cyc("br_go",     1, OP_B, 5'd0, 5'd4, 5'd5, 1, 0, mk(0, 1, 1, 0, 0, 4'd3));
      cyc("br_bub",    0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, mk(0, 0, 0, 0, 0, 4'd3));

      // Taken branch held behind a load stall
      cyc("lw_x10",    1, OP_LOAD, 5'd10, 5'd2, 5'd0, 0, 0, mk(0, 0, 0, 0, 0, 4'd3));
      cyc("brst_1",    1, OP_B, 5'd0, 5'd1, 5'd2, 1, 0, mk(1, 0, 0, 0, 0, 4'd3));
      cyc("brst_2",    1, OP_B, 5'd0, 5'd1, 5'd2, 1, 0, mk(1, 0, 0, 0, 0, 4'd4));
      cyc("brst_rel",  1, OP_B, 5'd0, 5'd1, 5'd2, 1, 1, mk(0, 1, 0, 0, 0, 4'd5));
      cyc("brst_bub",  0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, mk(0, 0, 0, 0, 0, 4'd5));

      // Timeout: load never returns; counter saturates at 15 along the way
      cyc("to_lw",     1, OP_LOAD, 5'd11, 5'd1, 5'd0, 0, 0, mk(0, 0, 0, 0, 0, 4'd5));
      cyc("to_k0",     1, OP_R, 5'd12, 5'd11, 5'd11, 0, 0, mk(1, 0, 1, 1, 0, 4'd5));
      for (int k = 1; k <= 16; k++) begin
         cyc($sformatf("to_k%0d", k), 1, OP_R, 5'd12, 5'd11, 5'd11, 0, 0,
             mk(1, 0, 1, 1, 0, (5 + k > 15) ? 4'd15 : 4'(5 + k)));
      end
      cyc("halt_br",   1, OP_B, 5'd0, 5'd11, 5'd11, 1, 0, mk(1, 0, 0, 0, 1, 4'd15));
      cyc("halt_dv",   1, OP_B, 5'd0, 5'd11, 5'd11, 1, 1, mk(1, 0, 0, 0, 1, 4'd15));
      cyc("halt_hold", 1, OP_R, 5'd12, 5'd11, 5'd11, 0, 0, mk(1, 0, 0, 0, 1, 4'd15));

      // Asynchronous reset in HALT, away from any clock edge
      drive(1'b1, OP_R, 5'd12, 5'd11, 5'd11, 1'b0, 1'b0);
      rst = 1'b1;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 4'd0));
      #2;
      compare_out("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Normal operation after recovery
      cyc("post_add",  1, OP_R, 5'd5, 5'd1, 5'd2, 0, 0, mk(0, 0, 0, 0, 0, 4'd0));
      cyc("post_sub",  1, OP_R, 5'd6, 5'd5, 5'd5, 0, 0, mk(0, 0, 1, 1, 0, 4'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
